// File: rtl/fifo_rd_stream.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional statistics outputs (words_out, empty_polls) are enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BACKOFF_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_val,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           words_out,
    output logic [15:0]           empty_polls
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POLL    = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    localparam logic [7:0] BO_LAST = 8'(BACKOFF_CYCLES - 1);

    state_t                  state, state_n;
    logic                    resp_q;
    logic                    seen_q, seen_n;
    logic [1:0]              count, count_n, count_after_pop;
    logic [DATA_WIDTH-1:0]   buf0, buf1, buf0_n, buf1_n;
    logic [7:0]              bo_cnt, bo_cnt_n;
    logic                    rd_en_n;
    logic                    push, pop, empty_resp;
    logic [2:0]              credit;

    assign out_valid = (count != 2'd0);
    assign out_data  = buf0;

    // Skid buffer: head is buf0; a pop shifts buf1 down before the push lands
    always_comb begin
        push            = resp_q & fifo_rd_val;
        empty_resp      = resp_q & ~fifo_rd_val;
        pop             = out_valid & out_ready;
        count_after_pop = count - {1'b0, pop};
        count_n         = count_after_pop + {1'b0, push};
        buf0_n          = buf0;
        buf1_n          = buf1;
        if (pop) begin
            buf0_n = buf1;
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                buf0_n = fifo_rd_data;
            end else begin
                buf1_n = fifo_rd_data;
            end
        end
    end

    always_comb begin
        state_n  = state;
        bo_cnt_n = bo_cnt;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = POLL;
                end
            end
            POLL: begin
                if (empty_resp) begin
                    state_n  = BACKOFF;
                    bo_cnt_n = '0;
                end else if (!enable) begin
                    state_n = IDLE;
                end
            end
            BACKOFF: begin
                if (bo_cnt == BO_LAST) begin
                    state_n  = enable ? POLL : IDLE;
                    bo_cnt_n = '0;
                end else begin
                    bo_cnt_n = bo_cnt + 8'd1;
                end
            end
            default: begin
                state_n  = IDLE;
                bo_cnt_n = '0;
            end
        endcase

        // A second read may overlap the first only once this poll has returned data,
        // so an empty FIFO is probed with single reads.
        seen_n  = (state_n == POLL) && (seen_q || push);
        credit  = {1'b0, count_n} + {2'b00, fifo_rd_en};
        rd_en_n = (state_n == POLL) && (credit <= 3'd1) && (!fifo_rd_en || seen_n);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            resp_q     <= 1'b0;
            seen_q     <= 1'b0;
            count      <= '0;
            buf0       <= '0;
            buf1       <= '0;
            bo_cnt     <= '0;
        end else begin
            state      <= state_n;
            fifo_rd_en <= rd_en_n;
            resp_q     <= fifo_rd_en;
            seen_q     <= seen_n;
            count      <= count_n;
            buf0       <= buf0_n;
            buf1       <= buf1_n;
            bo_cnt     <= bo_cnt_n;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            words_out   <= '0;
            empty_polls <= '0;
        end else begin
            if (pop && (words_out != '1)) begin
                words_out <= words_out + 32'd1;
            end
            if (empty_resp && (empty_polls != '1)) begin
                empty_polls <= empty_polls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a registered-read FIFO model and stream monitor.
module tb_fifo_rd_stream;

    localparam int BO = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_val;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] words_out;
    logic [15:0] empty_polls;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    logic       rd_seen;
    logic       resp_live;
    int         occ_m;
    int         max_occ;

    fifo_rd_stream #(
        .DATA_WIDTH     (8),
        .BACKOFF_CYCLES (BO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_val  (fifo_rd_val),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .words_out    (words_out),
        .empty_polls  (empty_polls)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered FIFO: a read in cycle c presents data/valid during cycle c+1 and holds it
    initial begin
        fifo_rd_data = '0;
        fifo_rd_val  = 1'b0;
        rd_seen      = 1'b0;
        resp_live    = 1'b0;
        forever begin
            @(negedge clk);
            rd_seen = fifo_rd_en;
            @(posedge clk);
            #1;
            resp_live = rd_seen;
            if (rd_seen) begin
                if (fifo_q.size() > 0) begin
                    fifo_rd_data = fifo_q.pop_front();
                    fifo_rd_val  = 1'b1;
                end else begin
                    fifo_rd_val = 1'b0;
                end
            end
        end
    end

    // Stream monitor and bench-side occupancy tracking
    initial begin
        occ_m   = 0;
        max_occ = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                occ_m = 0;
            end else begin
                if (out_valid && out_ready) begin
                    out_q.push_back(out_data);
                    occ_m = occ_m - 1;
                end
                if (resp_live && fifo_rd_val) occ_m = occ_m + 1;
                if (occ_m > max_occ) max_occ = occ_m;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        reset     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        fifo_q.delete();
        out_q.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
`ifdef FIFO_RD_STREAM_STATS_EN
        checks++;
        if (words_out !== 32'd0 || empty_polls !== 16'd0) begin
            failures++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", words_out, empty_polls);
        end
`endif
    endtask

    task automatic test_stream();
        int         gap;
        bit         found;
        bit         done;
        logic [7:0] want [3];
        logic [7:0] got;
        want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
        apply_reset();
        for (int i = 0; i < 3; i++) fifo_q.push_back(want[i]);
        enable    = 1'b1;
        out_ready = 1'b1;
        gap = 0; found = 1'b0; done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!found) begin
                if (resp_live && !fifo_rd_val) found = 1'b1;
            end else if (!done) begin
                if (fifo_rd_en) done = 1'b1;
                else gap++;
            end
        end
        checks++;
        if (!(found && done)) begin failures++; $display("FAIL stream_backoff_end: got found=%b done=%b expected 1/1", found, done); end
        checks++;
        if (gap != BO) begin failures++; $display("FAIL stream_backoff_gap: got %0d expected %0d", gap, BO); end
        checks++;
        if (out_q.size() != 3) begin failures++; $display("FAIL stream_count: got %0d expected 3", out_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (out_q.size() > i) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== want[i]) begin failures++; $display("FAIL stream_word%0d: got %h expected %h", i, got, want[i]); end
        end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        int         reads;
        bit         stable;
        logic [7:0] want [5];
        logic [7:0] got;
        for (int i = 0; i < 5; i++) want[i] = 8'(8'hA1 + i);
        apply_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(want[i]);
        enable    = 1'b1;
        out_ready = 1'b0;
        reads  = 0;
        stable = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (fifo_rd_en) reads++;
            if (out_valid && out_data !== want[0]) stable = 1'b0;
        end
        checks++;
        if (reads != 2) begin failures++; $display("FAIL bp_reads: got %0d expected 2", reads); end
        checks++;
        if (!stable) begin failures++; $display("FAIL bp_head_stable: got unstable expected %h held", want[0]); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== want[0]) begin
            failures++; $display("FAIL bp_head: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, want[0]);
        end
        tick();
        out_ready = 1'b1;
        for (int n = 0; n < 60 && out_q.size() < 5; n++) tick();
        repeat (10) tick();
        checks++;
        if (out_q.size() != 5) begin failures++; $display("FAIL bp_count: got %0d expected 5", out_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (out_q.size() > i) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== want[i]) begin failures++; $display("FAIL bp_word%0d: got %h expected %h", i, got, want[i]); end
        end
`ifdef FIFO_RD_STREAM_STATS_EN
        checks++;
        if (words_out !== 32'd5) begin failures++; $display("FAIL bp_words_out: got %0d expected 5", words_out); end
`endif
        enable = 1'b0;
    endtask

    task automatic test_empty_poll();
        int  rises;
        int  highs;
        int  rise_at [8];
        bit  prev;
        bit  saw_valid;
`ifdef FIFO_RD_STREAM_STATS_EN
        logic [15:0] ep_first;
        logic [15:0] ep_second;
        ep_first = '0; ep_second = '0;
`endif
        apply_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        rises = 0; highs = 0; prev = 1'b0; saw_valid = 1'b0;
        for (int n = 0; n < 21; n++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
            if (fifo_rd_en) highs++;
            if (fifo_rd_en && !prev) begin
`ifdef FIFO_RD_STREAM_STATS_EN
                if (rises == 0) ep_first = empty_polls;
                if (rises == 1) ep_second = empty_polls;
`endif
                if (rises < 8) rise_at[rises] = n;
                rises++;
            end
            prev = fifo_rd_en;
        end
        checks++;
        if (rises != 4) begin failures++; $display("FAIL poll_pulses: got %0d expected 4", rises); end
        checks++;
        if (highs != rises) begin failures++; $display("FAIL poll_width: got %0d high cycles expected %0d", highs, rises); end
        for (int i = 1; i < 4; i++) begin
            if (i < rises) begin
                checks++;
                if (rise_at[i] - rise_at[i-1] != 2 + BO) begin
                    failures++; $display("FAIL poll_period%0d: got %0d expected %0d", i, rise_at[i] - rise_at[i-1], 2 + BO);
                end
            end
        end
        checks++;
        if (saw_valid) begin failures++; $display("FAIL poll_no_valid: got out_valid=1 expected 0"); end
`ifdef FIFO_RD_STREAM_STATS_EN
        checks++;
        if (ep_second - ep_first !== 16'd1) begin
            failures++; $display("FAIL poll_empty_count: got %0d expected 1", ep_second - ep_first);
        end
`endif
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'hB1 + i));
        enable    = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL mid_second_read: got %b expected 1", fifo_rd_en); end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en: got %b expected 0", fifo_rd_en); end
        out_q.delete();
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (30) tick();
        checks++;
        if (out_q.size() != 2) begin failures++; $display("FAIL mid_count: got %0d expected 2", out_q.size()); end
        got = (out_q.size() > 0) ? out_q[0] : 8'hxx;
        checks++;
        if (got !== 8'hB3) begin failures++; $display("FAIL mid_first_after: got %h expected b3", got); end
        got = (out_q.size() > 1) ? out_q[1] : 8'hxx;
        checks++;
        if (got !== 8'hB4) begin failures++; $display("FAIL mid_second_after: got %h expected b4", got); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int         extra;
        logic [7:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'hC1 + i));
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        enable = 1'b0;
        extra  = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (n > 0 && fifo_rd_en) extra++;
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL drop_reads: got %0d expected 0", extra); end
        checks++;
        if (out_q.size() != 1) begin failures++; $display("FAIL drop_count: got %0d expected 1", out_q.size()); end
        got = (out_q.size() > 0) ? out_q[0] : 8'hxx;
        checks++;
        if (got !== 8'hC1) begin failures++; $display("FAIL drop_word: got %h expected c1", got); end
    endtask

    task automatic test_random();
        logic [7:0] w;
        logic [7:0] got;
        int         cyc;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 200; i++) begin
            w = 8'($urandom_range(0, 255));
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        max_occ = 0;
        enable  = 1'b1;
        cyc     = 0;
        while (out_q.size() < 200 && cyc < 4000) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (out_q.size() != 200) begin failures++; $display("FAIL rand_count: got %0d expected 200", out_q.size()); end
        for (int i = 0; i < 200; i++) begin
            got = (out_q.size() > i) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL rand_word%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        checks++;
        if (max_occ > 2) begin failures++; $display("FAIL rand_occupancy: got %0d expected <=2", max_occ); end
        enable = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_poll();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
